countdown_timer: RTL



---
 rtl/timer_pkg.sv | 19 +
 rtl/countdown_timer_if.sv | 27 ++
 rtl/bcd_digit_dec.sv | 24 ++
 rtl/countdown_timer.sv | 116 +++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types, BCD limits and input clamping for the countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StPause   = 2'd2,
    StExpired = 2'd3
  } timer_state_e;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] TENS_SEC_MAX = 4'd5;

  // Saturate a preset digit to the largest legal value for its position.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Preset/control inputs and BCD/status outputs of the countdown timer.
interface countdown_timer_if;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic [3:0] S_in1;
  logic [3:0] S_in0;
  logic       LD_timer;
  logic       start;
  logic       pause;
  logic       STOP_al;
  logic [3:0] M_out1;
  logic [3:0] M_out0;
  logic [3:0] S_out1;
  logic [3:0] S_out0;
  logic       running;
  logic       Expired;

  modport master (
    output M_in1, M_in0, S_in1, S_in0, LD_timer, start, pause, STOP_al,
    input  M_out1, M_out0, S_out1, S_out0, running, Expired
  );

  modport slave (
    input  M_in1, M_in0, S_in1, S_in0, LD_timer, start, pause, STOP_al,
    output M_out1, M_out0, S_out1, S_out0, running, Expired
  );
endinterface

// File: rtl/bcd_digit_dec.sv
// One stage of a BCD down-counting borrow chain.
module bcd_digit_dec (
  input  logic [3:0] digit_i,
  input  logic [3:0] max_i,
  input  logic       borrow_i,
  output logic [3:0] digit_o,
  output logic       borrow_o
);

  // Decrement on borrow-in; zero wraps to max_i and passes the borrow on.
  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (borrow_i) begin
      if (digit_i == 4'd0) begin
        digit_o  = max_i;
        borrow_o = 1'b1;
      end else begin
        digit_o = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS kitchen timer: load, run/pause, count down at 1 Hz, flag expiry until acknowledged.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned BEEP_SECS   = 30,
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic                clk_1s,
  input  logic                reset,
  countdown_timer_if.slave    bus_io
);

  localparam int unsigned BeepW = (BEEP_SECS == 0) ? 1 : $clog2(BEEP_SECS + 1);

  timer_state_e     state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;        // {M1, M0, S1, S0}
  logic [15:0]      preset_q, preset_d;
  logic [BeepW-1:0] beep_q, beep_d;

  logic [3:0]  dec_s0, dec_s1, dec_m0, dec_m1;
  logic        brw_s0, brw_s1, brw_m0, underflow;
  logic [15:0] dec_cnt, load_val;
  logic        cnt_zero, dec_zero, beep_done;
  logic [31:0] beep_ext;

  // The chain always borrows into S0; a borrow out of M1 means the count is 00:00.
  bcd_digit_dec u_dec_s0 (
    .digit_i (cnt_q[3:0]),   .max_i (DIGIT_MAX),    .borrow_i (1'b1),
    .digit_o (dec_s0),       .borrow_o (brw_s0)
  );
  bcd_digit_dec u_dec_s1 (
    .digit_i (cnt_q[7:4]),   .max_i (TENS_SEC_MAX), .borrow_i (brw_s0),
    .digit_o (dec_s1),       .borrow_o (brw_s1)
  );
  bcd_digit_dec u_dec_m0 (
    .digit_i (cnt_q[11:8]),  .max_i (DIGIT_MAX),    .borrow_i (brw_s1),
    .digit_o (dec_m0),       .borrow_o (brw_m0)
  );
  bcd_digit_dec u_dec_m1 (
    .digit_i (cnt_q[15:12]), .max_i (DIGIT_MAX),    .borrow_i (brw_m0),
    .digit_o (dec_m1),       .borrow_o (underflow)
  );

  assign dec_cnt  = {dec_m1, dec_m0, dec_s1, dec_s0};
  assign cnt_zero = underflow;
  assign dec_zero = (dec_cnt == 16'h0000);
  assign load_val = {clamp_digit(bus_io.M_in1, DIGIT_MAX), clamp_digit(bus_io.M_in0, DIGIT_MAX),
                     clamp_digit(bus_io.S_in1, TENS_SEC_MAX), clamp_digit(bus_io.S_in0, DIGIT_MAX)};
  assign beep_ext  = 32'(beep_q);
  assign beep_done = (BEEP_SECS != 0) && ((beep_ext + 32'd1) == BEEP_SECS);

  // Next-state: load beats pause beats start; expiry and acknowledge handling.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    preset_d = preset_q;
    beep_d   = '0;
    unique case (state_q)
      StIdle, StPause: begin
        if (bus_io.LD_timer) begin
          cnt_d    = load_val;
          preset_d = load_val;
          state_d  = StIdle;
        end else if (bus_io.pause) begin
          state_d = state_q;
        end else if (bus_io.start && !cnt_zero) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus_io.pause) begin
          state_d = StPause;
        end else begin
          if (!cnt_zero) cnt_d = dec_cnt;
          if (cnt_zero || dec_zero) state_d = StExpired;
        end
      end
      StExpired: begin
        if (bus_io.LD_timer) begin
          cnt_d    = load_val;
          preset_d = load_val;
          state_d  = StIdle;
        end else if (bus_io.STOP_al || beep_done) begin
          state_d = StIdle;
          cnt_d   = (AUTO_RELOAD != 0) ? preset_q : 16'h0000;
        end else begin
          beep_d = beep_q + BeepW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 16'h0000;
      preset_q <= 16'h0000;
      beep_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      preset_q <= preset_d;
      beep_q   <= beep_d;
    end
  end

  assign bus_io.M_out1  = cnt_q[15:12];
  assign bus_io.M_out0  = cnt_q[11:8];
  assign bus_io.S_out1  = cnt_q[7:4];
  assign bus_io.S_out0  = cnt_q[3:0];
  assign bus_io.running = (state_q == StRun);
  assign bus_io.Expired = (state_q == StExpired);

endmodule
